// File: rtl/mul_result_unit_if.sv
// Product capture and result-bus signals shared between the multiplier side,
// the result unit and its consumer.
interface mul_result_if;
  logic [66:0] prod_in;
  logic        prod_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        out_ovf;
  logic        out_sext_err;

  modport slave (
    input  prod_in, prod_valid, out_ready,
    output out_data, out_valid, out_last, out_ovf, out_sext_err
  );

  modport master (
    output prod_in, prod_valid, out_ready,
    input  out_data, out_valid, out_last, out_ovf, out_sext_err
  );
endinterface

// File: rtl/mul_result_unit.sv
// Queues 67-bit Booth multiplier products and streams each as two 32-bit beats
// (low word, then high word) with overflow / sign-extension flags.
module mul_result_unit #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr_err,
  output logic        o_full,
  output logic        o_drop_err,
  mul_result_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0] CNT_TWO   = (AW+1)'(2);

  typedef struct packed {
    logic [63:0] res;
    logic        ovf;
    logic        sext;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  logic [31:0]   r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic          r_out_ovf;
  logic          r_out_sext;
  logic          r_full;
  logic          r_drop_err;

  entry_t        w_new;
  entry_t        w_head;
  entry_t        w_nh;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [AW:0]   w_count_next;
  logic [AW-1:0] w_nh_idx;
  logic          w_nh_stored;

  always_comb begin
    w_new.res  = bus.prod_in[63:0];
    w_new.ovf  = ~((&bus.prod_in[63:31]) | ~(|bus.prod_in[63:31]));
    w_new.sext = bus.prod_in[66:64] != {3{bus.prod_in[63]}};
  end

  assign w_pop  = r_out_valid & bus.out_ready & r_out_last;
  assign w_push = bus.prod_valid & ((r_count < CNT_DEPTH) | w_pop);
  assign w_drop = bus.prod_valid & ~w_push;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // Head after this edge: may be the product being captured right now when
  // the queue holds nothing else, which gives single-cycle latency.
  assign w_head      = r_mem[r_rd_ptr];
  assign w_nh_idx    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_nh_stored = w_pop ? (r_count >= CNT_TWO) : (r_count >= CNT_ONE);
  assign w_nh        = w_nh_stored ? r_mem[w_nh_idx] : w_new;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_sext  <= 1'b0;
      r_full      <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CNT_DEPTH);

      if (w_drop)         r_drop_err <= 1'b1;
      else if (i_clr_err) r_drop_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_count_next != '0) begin
            r_state     <= S_LO;
            r_out_valid <= 1'b1;
            r_out_data  <= w_nh.res[31:0];
            r_out_last  <= 1'b0;
            r_out_ovf   <= w_nh.ovf;
            r_out_sext  <= w_nh.sext;
          end
        end
        S_LO: begin
          if (bus.out_ready) begin
            r_state    <= S_HI;
            r_out_data <= w_head.res[63:32];
            r_out_last <= 1'b1;
          end
        end
        S_HI: begin
          if (bus.out_ready) begin
            if (w_count_next != '0) begin
              r_state    <= S_LO;
              r_out_data <= w_nh.res[31:0];
              r_out_last <= 1'b0;
              r_out_ovf  <= w_nh.ovf;
              r_out_sext <= w_nh.sext;
            end else begin
              r_state     <= S_IDLE;
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_out_last  <= 1'b0;
              r_out_ovf   <= 1'b0;
              r_out_sext  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out_data     = r_out_data;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_last     = r_out_last;
  assign bus.out_ovf      = r_out_ovf;
  assign bus.out_sext_err = r_out_sext;
  assign o_full           = r_full;
  assign o_drop_err       = r_drop_err;
endmodule

// File: tb/tb_mul_result_unit.sv
// Directed bench for mul_result_unit: table of single products plus stall,
// full-queue, drop and mid-transfer reset sequences.
module tb_mul_result_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_err = 1'b0;
  logic full;
  logic drop_err;

  mul_result_if bus();

  mul_result_unit #(.DEPTH(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clr_err  (clr_err),
    .o_full     (full),
    .o_drop_err (drop_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [66:0] prod;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ovf;
    logic        sext;
  } vec_t;

  vec_t vecs [8];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_beat(input string name, input logic [31:0] d, input logic l,
                          input logic o, input logic s);
    chk({name, ".valid"}, 64'(bus.out_valid), 64'(1));
    chk({name, ".data"},  64'(bus.out_data),  64'(d));
    chk({name, ".last"},  64'(bus.out_last),  64'(l));
    chk({name, ".ovf"},   64'(bus.out_ovf),   64'(o));
    chk({name, ".sext"},  64'(bus.out_sext_err), 64'(s));
  endtask

  task automatic push(input logic [66:0] p);
    bus.prod_in    = p;
    bus.prod_valid = 1'b1;
    cyc();
    bus.prod_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{67'd6408,                      32'h0000_1908, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{67'h7_FFFF_FFFF_FFFF_E6F8,     32'hFFFF_E6F8, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[2] = '{67'h0_0000_0001_0000_0000,     32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0};
    vecs[3] = '{67'h0,                         32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{67'h7_FFFF_FFFF_8000_0000,     32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[5] = '{67'h0_0000_0000_8000_0000,     32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{67'h0_8000_0000_0000_0000,     32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1};
    vecs[7] = '{67'h0_0000_0000_7FFF_FFFF,     32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};

    bus.prod_in    = '0;
    bus.prod_valid = 1'b0;
    bus.out_ready  = 1'b0;
    cyc();
    cyc();
    chk("rst.valid",    64'(bus.out_valid),    64'(0));
    chk("rst.data",     64'(bus.out_data),     64'(0));
    chk("rst.last",     64'(bus.out_last),     64'(0));
    chk("rst.ovf",      64'(bus.out_ovf),      64'(0));
    chk("rst.sext",     64'(bus.out_sext_err), 64'(0));
    chk("rst.full",     64'(full),             64'(0));
    chk("rst.drop_err", 64'(drop_err),         64'(0));
    rst = 1'b0;
    cyc();

    // Single products with the consumer always ready.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(vecs[i].prod);
      chk_beat($sformatf("vec%0d.lo", i), vecs[i].lo, 1'b0, vecs[i].ovf, vecs[i].sext);
      cyc();
      chk_beat($sformatf("vec%0d.hi", i), vecs[i].hi, 1'b1, vecs[i].ovf, vecs[i].sext);
      cyc();
      chk($sformatf("vec%0d.idle", i), 64'(bus.out_valid), 64'(0));
      chk($sformatf("vec%0d.full", i), 64'(full), 64'(0));
    end

    // Stalled consumer: fill, drop the third, then drain in order.
    bus.out_ready = 1'b0;
    push(67'd1000);
    push(67'h0_0000_0002_0000_0005);
    chk("drop.full2", 64'(full), 64'(1));
    chk("drop.err_before", 64'(drop_err), 64'(0));
    push(67'd77);
    chk("drop.full3", 64'(full), 64'(1));
    chk("drop.err_after", 64'(drop_err), 64'(1));
    chk_beat("drop.p1lo_stall", 32'd1000, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_beat("drop.p1lo_hold", 32'd1000, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    chk_beat("drop.p1hi", 32'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_beat("drop.p2lo", 32'd5, 1'b0, 1'b1, 1'b0);
    cyc();
    chk_beat("drop.p2hi", 32'd2, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("drop.idle", 64'(bus.out_valid), 64'(0));
    chk("drop.empty", 64'(full), 64'(0));
    chk("drop.err_sticky", 64'(drop_err), 64'(1));
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    chk("drop.clr", 64'(drop_err), 64'(0));

    // Full queue, pop on the HI beat and push in the same cycle.
    bus.out_ready = 1'b0;
    push(67'd11);
    push(67'd22);
    chk("pp.full", 64'(full), 64'(1));
    bus.out_ready = 1'b1;
    cyc();
    chk_beat("pp.q1hi", 32'd0, 1'b1, 1'b0, 1'b0);
    push(67'd33);
    chk("pp.full_kept", 64'(full), 64'(1));
    chk("pp.no_drop", 64'(drop_err), 64'(0));
    chk_beat("pp.q2lo", 32'd22, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_beat("pp.q2hi", 32'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_beat("pp.q3lo", 32'd33, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_beat("pp.q3hi", 32'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("pp.idle", 64'(bus.out_valid), 64'(0));
    chk("pp.empty", 64'(full), 64'(0));

    // Reset asserted in the HI state with two entries queued.
    bus.out_ready = 1'b0;
    push(67'd101);
    push(67'd102);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
    chk_beat("mr.hi", 32'd0, 1'b1, 1'b0, 1'b0);
    chk("mr.full", 64'(full), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("mr.valid", 64'(bus.out_valid), 64'(0));
    chk("mr.last",  64'(bus.out_last),  64'(0));
    chk("mr.full0", 64'(full),          64'(0));
    cyc();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("mr.stays_idle", 64'(bus.out_valid), 64'(0));
    push(67'd555);
    chk_beat("mr.newlo", 32'd555, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_beat("mr.newhi", 32'd0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk("mr.final_idle", 64'(bus.out_valid), 64'(0));
    cyc();
    chk("mr.no_stale", 64'(bus.out_valid), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
